// File: rtl/upcnt_pkg.sv
// Shared types, digit limits and BCD helpers for the three-digit count-up timer.
package upcnt_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    bcd_t d2;
    bcd_t d1;
    bcd_t d0;
  } bcd3_t;

  localparam bcd_t LIMIT_1   = 4'd9;
  localparam bcd_t LIMIT_10  = 4'd5;
  localparam bcd_t LIMIT_100 = 4'd1;

  function automatic bcd_t bcd_sat(input bcd_t d, input bcd_t lim);
    return (d > lim) ? lim : d;
  endfunction

  function automatic bcd_t bcd_wrap_inc(input bcd_t d, input bcd_t lim);
    return (d == lim) ? 4'd0 : d + 4'd1;
  endfunction

  // Whole-count increment, mirrors the carry chain of the digit instances.
  function automatic bcd3_t bcd3_inc(input bcd3_t c);
    bcd3_t n;
    n.d0 = bcd_wrap_inc(c.d0, LIMIT_1);
    n.d1 = (c.d0 == LIMIT_1) ? bcd_wrap_inc(c.d1, LIMIT_10) : c.d1;
    n.d2 = ((c.d0 == LIMIT_1) && (c.d1 == LIMIT_10)) ? bcd_wrap_inc(c.d2, LIMIT_100) : c.d2;
    return n;
  endfunction

endpackage

// File: rtl/bcd_up_digit.sv
// One BCD counter digit with programmable wrap limit; carry is combinational
// so digits can be chained within a single clock.
module bcd_up_digit
  import upcnt_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  input  bcd_t limit,
  output bcd_t value,
  output logic carry
);

  bcd_t value_d;
  bcd_t value_q;

  // Next digit value: clear wins over increment.
  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = 4'd0;
    end else if (inc) begin
      value_d = bcd_wrap_inc(value_q, limit);
    end else begin
      value_d = value_q;
    end
  end

  // Digit register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_q <= 4'd0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign carry = inc && (value_q == limit);

endmodule

// File: rtl/three_digit_bcd_upcnt.sv
// Three-digit BCD stopwatch (max 1:59): run/pause, lap freeze, clear, and
// a target value that stops the count and lights all LEDs.
module three_digit_bcd_upcnt
  import upcnt_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        start_stop,
  input  logic        lap,
  input  logic        clear,
  input  logic [3:0]  target_1,
  input  logic [3:0]  target_10,
  input  logic [3:0]  target_100,
  output logic [3:0]  digit0,
  output logic [3:0]  digit1,
  output logic [3:0]  digit2,
  output logic        running,
  output logic        done,
  output logic [15:0] LED_control
);

  state_t state_q, state_d;
  bcd3_t  target_q, target_d, target_sat_s;
  bcd3_t  lap_q, lap_d;
  bcd3_t  disp_q, disp_d;
  bcd3_t  cnt_s, cnt_next_s, cnt_nx_s;
  logic   lap_hold_q, lap_hold_d;
  logic   cnt_clr_s, cnt_inc_s;
  logic   carry0_s, carry1_s, carry2_s;
  logic   running_q, done_q;
  logic [15:0] led_q;

  bcd_up_digit u_digit0 (
    .clk(clk), .rst_n(rst_n), .clr(cnt_clr_s), .inc(cnt_inc_s),
    .limit(LIMIT_1), .value(cnt_s.d0), .carry(carry0_s)
  );

  bcd_up_digit u_digit1 (
    .clk(clk), .rst_n(rst_n), .clr(cnt_clr_s), .inc(carry0_s),
    .limit(LIMIT_10), .value(cnt_s.d1), .carry(carry1_s)
  );

  bcd_up_digit u_digit2 (
    .clk(clk), .rst_n(rst_n), .clr(cnt_clr_s), .inc(carry1_s),
    .limit(LIMIT_100), .value(cnt_s.d2), .carry(carry2_s)
  );

  assign target_sat_s = {bcd_sat(target_100, LIMIT_100),
                         bcd_sat(target_10,  LIMIT_10),
                         bcd_sat(target_1,   LIMIT_1)};
  assign cnt_next_s   = bcd3_inc(cnt_s);

  // FSM next state, target capture, lap freeze and next displayed value.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    lap_d      = lap_q;
    lap_hold_d = lap_hold_q;
    cnt_clr_s  = 1'b0;
    cnt_inc_s  = 1'b0;
    cnt_nx_s   = cnt_s;
    if (clear) begin
      state_d    = IDLE;
      target_d   = 12'd0;
      lap_d      = 12'd0;
      lap_hold_d = 1'b0;
      cnt_clr_s  = 1'b1;
      cnt_nx_s   = 12'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_stop) begin
            target_d = target_sat_s;
            state_d  = (target_sat_s == 12'd0) ? DONE : RUN;
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          if (start_stop) begin
            state_d = PAUSE;
          end else if (tick) begin
            cnt_inc_s = 1'b1;
            cnt_nx_s  = cnt_next_s;
            // A top-digit carry can only occur past 1:59; treat it as terminal.
            state_d   = ((cnt_next_s == target_q) || carry2_s) ? DONE : RUN;
          end else begin
            state_d = RUN;
          end
        end
        PAUSE: begin
          state_d = start_stop ? RUN : PAUSE;
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d    = IDLE;
          target_d   = 12'd0;
          lap_d      = 12'd0;
          lap_hold_d = 1'b0;
          cnt_clr_s  = 1'b1;
          cnt_nx_s   = 12'd0;
        end
      endcase

      if (lap && ((state_q == RUN) || (state_q == PAUSE))) begin
        if (lap_hold_q) begin
          lap_hold_d = 1'b0;
        end else begin
          lap_hold_d = 1'b1;
          lap_d      = cnt_s;
        end
      end else begin
        lap_hold_d = lap_hold_d;
      end

      if (state_d == DONE) begin
        lap_hold_d = 1'b0;
      end else begin
        lap_hold_d = lap_hold_d;
      end
    end
    disp_d = lap_hold_d ? lap_d : cnt_nx_s;
  end

  // State, target, lap and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      target_q   <= 12'd0;
      lap_q      <= 12'd0;
      lap_hold_q <= 1'b0;
      disp_q     <= 12'd0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      led_q      <= 16'h0000;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      lap_q      <= lap_d;
      lap_hold_q <= lap_hold_d;
      disp_q     <= disp_d;
      running_q  <= (state_d == RUN);
      done_q     <= (state_d == DONE);
      led_q      <= (state_d == DONE) ? 16'hFFFF : 16'h0000;
    end
  end

  assign digit0      = disp_q.d0;
  assign digit1      = disp_q.d1;
  assign digit2      = disp_q.d2;
  assign running     = running_q;
  assign done        = done_q;
  assign LED_control = led_q;

endmodule

// File: tb/tb_three_digit_bcd_upcnt.sv
// Directed bench for the three-digit BCD stopwatch with hand-derived expectations.
module tb_three_digit_bcd_upcnt;

  logic        clk = 1'b0;
  logic        rst_n, tick, start_stop, lap, clear;
  logic [3:0]  target_1, target_10, target_100;
  logic [3:0]  digit0, digit1, digit2;
  logic        running, done;
  logic [15:0] LED_control;
  logic [11:0] disp_w;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign disp_w = {digit2, digit1, digit0};

  three_digit_bcd_upcnt dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start_stop(start_stop),
    .lap(lap), .clear(clear), .target_1(target_1), .target_10(target_10),
    .target_100(target_100), .digit0(digit0), .digit1(digit1), .digit2(digit2),
    .running(running), .done(done), .LED_control(LED_control)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Seconds -> m:ss as three BCD nibbles.
  function automatic logic [11:0] to_bcd(input int s);
    logic [3:0] m, t, o;
    m = 4'(s / 60);
    t = 4'((s % 60) / 10);
    o = 4'(s % 10);
    return {m, t, o};
  endfunction

  task automatic cyc(input logic ss, input logic tk, input logic lp, input logic cl);
    @(negedge clk);
    start_stop = ss;
    tick       = tk;
    lap        = lp;
    clear      = cl;
    @(posedge clk);
    #1;
    start_stop = 1'b0;
    tick       = 1'b0;
    lap        = 1'b0;
    clear      = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) cyc(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic set_target(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    target_100 = h;
    target_10  = t;
    target_1   = o;
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
    set_target(4'd0, 4'd0, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_disp", 32'(disp_w), 32'h000);
    check_eq("rst_running", 32'(running), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_led", 32'(LED_control), 32'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Count to 0:12
    set_target(4'd0, 4'd1, 4'd2);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("t12_running", 32'(running), 32'd1);
    check_eq("t12_start_disp", 32'(disp_w), 32'h000);
    for (int i = 1; i <= 12; i++) begin
      ticks(1);
      check_eq("t12_disp", 32'(disp_w), 32'(to_bcd(i)));
      if (i == 11) check_eq("t12_not_done", 32'(done), 32'd0);
    end
    check_eq("t12_done", 32'(done), 32'd1);
    check_eq("t12_led", 32'(LED_control), 32'hFFFF);
    check_eq("t12_run_low", 32'(running), 32'd0);
    ticks(1);
    check_eq("t12_hold", 32'(disp_w), 32'h012);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("done_ignores_ss", 32'(done), 32'd1);

    // Double carry and 1:59 ceiling
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("clr_disp", 32'(disp_w), 32'h000);
    check_eq("clr_done", 32'(done), 32'd0);
    check_eq("clr_led", 32'(LED_control), 32'h0000);
    set_target(4'd1, 4'd5, 4'd9);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(59);
    check_eq("max_059", 32'(disp_w), 32'h059);
    ticks(1);
    check_eq("max_100", 32'(disp_w), 32'h100);
    ticks(59);
    check_eq("max_159", 32'(disp_w), 32'h159);
    check_eq("max_done", 32'(done), 32'd1);
    ticks(1);
    check_eq("max_nowrap", 32'(disp_w), 32'h159);

    // Pause with same-cycle tick; target not re-sampled on resume
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(5);
    check_eq("p_005", 32'(disp_w), 32'h005);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("p_running", 32'(running), 32'd0);
    check_eq("p_drop_tick", 32'(disp_w), 32'h005);
    set_target(4'd0, 4'd0, 4'd6);
    ticks(3);
    check_eq("p_held", 32'(disp_w), 32'h005);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("p_resume", 32'(running), 32'd1);
    ticks(1);
    check_eq("p_006", 32'(disp_w), 32'h006);
    check_eq("p_no_resample", 32'(done), 32'd0);

    // Lap freeze
    ticks(1);
    check_eq("lap_007", 32'(disp_w), 32'h007);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("lap_frozen", 32'(disp_w), 32'h007);
    ticks(4);
    check_eq("lap_still", 32'(disp_w), 32'h007);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("lap_release", 32'(disp_w), 32'h011);

    // Zero target goes straight to DONE
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    set_target(4'd0, 4'd0, 4'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("z_done", 32'(done), 32'd1);
    check_eq("z_led", 32'(LED_control), 32'hFFFF);
    check_eq("z_running", 32'(running), 32'd0);
    check_eq("z_disp", 32'(disp_w), 32'h000);

    // Saturated target 3:9F -> 1:59
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    set_target(4'd3, 4'd9, 4'd15);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("sat_running", 32'(running), 32'd1);
    ticks(118);
    check_eq("sat_158", 32'(disp_w), 32'h158);
    check_eq("sat_not_done", 32'(done), 32'd0);
    ticks(1);
    check_eq("sat_159", 32'(disp_w), 32'h159);
    check_eq("sat_done", 32'(done), 32'd1);

    // Clear with lap held and same-cycle tick
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    set_target(4'd1, 4'd5, 4'd9);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(30);
    check_eq("cl_030", 32'(disp_w), 32'h030);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(1);
    check_eq("cl_frozen", 32'(disp_w), 32'h030);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    check_eq("cl_disp", 32'(disp_w), 32'h000);
    check_eq("cl_running", 32'(running), 32'd0);
    check_eq("cl_done", 32'(done), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(1);
    check_eq("cl_restart", 32'(disp_w), 32'h001);

    // Reset mid-count
    ticks(5);
    check_eq("mr_006", 32'(disp_w), 32'h006);
    @(negedge clk);
    rst_n = 1'b0;
    tick  = 1'b1;
    @(posedge clk);
    #1;
    check_eq("mr_disp", 32'(disp_w), 32'h000);
    check_eq("mr_running", 32'(running), 32'd0);
    check_eq("mr_done", 32'(done), 32'd0);
    check_eq("mr_led", 32'(LED_control), 32'h0000);
    rst_n = 1'b1;
    tick  = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
